// File: rtl/fetch_stage.sv
// fetch_stage: instruction-fetch stage plus the IF/ID pipeline register.
//
// Purpose:
//   This module owns the fetch PC. It keeps at most one request outstanding
//   to a variable-latency instruction memory. It applies the hazard unit's
//   stall/flush controls and the execute-stage redirect. When memory has not
//   returned an instruction, it inserts a NOP bubble into decode.
//
// Ports:
//   clk          in   rising-edge clock
//   rst_n        in   asynchronous active-low reset
//   stall_f      in   hold PC / do not consume a fetched instruction
//   stall_d      in   hold the IF/ID register
//   flush_d      in   clear the IF/ID register to a bubble
//   pc_src_e     in   taken branch/jump resolved in execute
//   pc_target_e  in   redirect address (low two bits ignored)
//   imem_req     out  request valid this cycle (always accepted)
//   imem_addr    out  word-aligned request address
//   imem_rvalid  in   response valid (at most one per request, latency >= 1)
//   imem_rdata   in   response instruction
//   instr_d      out  instruction to decode
//   pc_d         out  PC of instr_d
//   pc_plus4_d   out  pc_d + 4
//   valid_d      out  instr_d is a real instruction (0 = bubble)
//
// Optional build macro FETCH_PERF_CNT_EN adds two saturating counters:
//   fetch_wait_cnt  out  cycles spent waiting (state not IDLE, nothing available)
//   fetch_kill_cnt  out  responses / buffered instructions discarded by redirects
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall_f,
  input  logic        stall_d,
  input  logic        flush_d,
  input  logic        pc_src_e,
  input  logic [31:0] pc_target_e,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr_d,
  output logic [31:0] pc_d,
  output logic [31:0] pc_plus4_d,
  output logic        valid_d
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0] fetch_wait_cnt,
  output logic [31:0] fetch_kill_cnt
`endif
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  state_t      state, state_n;
  logic [31:0] pc_f, pc_n;
  logic        kill, kill_n;
  logic [31:0] hold_instr, hold_n;

  logic        req_c;
  logic [31:0] addr_c;

  logic        resp;       // a response is present on the bus this cycle
  logic        avail;      // an instruction is ready to be handed to decode
  logic [31:0] fetched;
  logic [31:0] pc_plus4_f;
  logic [31:0] target;

  assign resp       = (state == S_WAIT) && imem_rvalid;
  assign avail      = (resp && !kill) || (state == S_HOLD);
  assign fetched    = (state == S_HOLD) ? hold_instr : imem_rdata;
  assign pc_plus4_f = pc_f + 32'd4;
  assign target     = pc_target_e & 32'hFFFF_FFFC;

  // The IDLE state requests unconditionally, so gate with reset
  // to keep the bus quiet while rst_n is low.
  assign imem_req  = req_c && rst_n;
  assign imem_addr = addr_c;

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      pc_f       <= RESET_PC;
      kill       <= 1'b0;
      hold_instr <= '0;
    end else begin
      state      <= state_n;
      pc_f       <= pc_n;
      kill       <= kill_n;
      hold_instr <= hold_n;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state and request logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_n = state;
    pc_n    = pc_f;
    kill_n  = kill;
    hold_n  = hold_instr;
    req_c   = 1'b0;
    addr_c  = pc_f;

    if (pc_src_e) begin
      pc_n = target;
      if ((state == S_WAIT) && !imem_rvalid) begin
        // The request is still in flight. Mark it killed and delay the
        // target fetch until the stale response has drained.
        kill_n = 1'b1;
      end else begin
        req_c   = 1'b1;
        addr_c  = target;
        state_n = S_WAIT;
        kill_n  = 1'b0;
      end
    end else begin
      unique case (state)
        S_IDLE: begin
          req_c   = 1'b1;
          addr_c  = pc_f;
          state_n = S_WAIT;
        end
        S_WAIT: begin
          if (imem_rvalid) begin
            if (kill) begin
              // Stale response drained. pc_f already holds the redirect target.
              kill_n  = 1'b0;
              req_c   = 1'b1;
              addr_c  = pc_f;
              state_n = S_WAIT;
            end else if (stall_f) begin
              hold_n  = imem_rdata;
              state_n = S_HOLD;
            end else begin
              pc_n    = pc_plus4_f;
              req_c   = 1'b1;
              addr_c  = pc_plus4_f;
              state_n = S_WAIT;
            end
          end
        end
        S_HOLD: begin
          if (!stall_f) begin
            pc_n    = pc_plus4_f;
            req_c   = 1'b1;
            addr_c  = pc_plus4_f;
            state_n = S_WAIT;
          end
        end
        default: begin
          state_n = S_IDLE;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // IF/ID pipeline register: flush > stall > load > bubble
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_d    <= NOP_INSTR;
      pc_d       <= '0;
      pc_plus4_d <= '0;
      valid_d    <= 1'b0;
    end else if (flush_d) begin
      instr_d <= NOP_INSTR;
      valid_d <= 1'b0;
    end else if (!stall_d) begin
      if (avail && !pc_src_e) begin
        instr_d    <= fetched;
        pc_d       <= pc_f;
        pc_plus4_d <= pc_plus4_f;
        valid_d    <= 1'b1;
      end else begin
        instr_d <= NOP_INSTR;
        valid_d <= 1'b0;
      end
    end
  end

`ifdef FETCH_PERF_CNT_EN
  // ---------------------------------------------------------------------------
  // Performance counters (saturating)
  // ---------------------------------------------------------------------------
  logic wait_evt;
  logic kill_evt;

  assign wait_evt = (state != S_IDLE) && !avail;
  // Count a discard when a redirect drops a live response or the HOLD buffer,
  // and also when a previously killed response finally arrives.
  assign kill_evt = (resp && (kill || pc_src_e)) || ((state == S_HOLD) && pc_src_e);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_wait_cnt <= '0;
      fetch_kill_cnt <= '0;
    end else begin
      if (wait_evt && (fetch_wait_cnt != '1)) fetch_wait_cnt <= fetch_wait_cnt + 32'd1;
      if (kill_evt && (fetch_kill_cnt != '1)) fetch_kill_cnt <= fetch_kill_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed self-checking bench for fetch_stage. A simple latency-programmable
// instruction memory answers each request with data derived from its address.
module tb_fetch_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [31:0] GARBAGE = 32'hBAD0_BAD0;

  logic        clk;
  logic        rst_n = 1'b1;
  logic        stall_f, stall_d, flush_d, pc_src_e;
  logic [31:0] pc_target_e;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic [31:0] instr_d, pc_d, pc_plus4_d;
  logic        valid_d;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_wait_cnt, fetch_kill_cnt;
`endif

  int checks = 0;
  int errors = 0;

  // memory model state
  logic        pend;
  logic [31:0] paddr;
  int unsigned lat;
  int unsigned wl;

  fetch_stage #(
    .RESET_PC (32'h0000_0000),
    .NOP_INSTR(NOP)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .stall_f    (stall_f),
    .stall_d    (stall_d),
    .flush_d    (flush_d),
    .pc_src_e   (pc_src_e),
    .pc_target_e(pc_target_e),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_rvalid(imem_rvalid),
    .imem_rdata (imem_rdata),
    .instr_d    (instr_d),
    .pc_d       (pc_d),
    .pc_plus4_d (pc_plus4_d),
    .valid_d    (valid_d)
`ifdef FETCH_PERF_CNT_EN
    ,
    .fetch_wait_cnt(fetch_wait_cnt),
    .fetch_kill_cnt(fetch_kill_cnt)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] mem_data(input logic [31:0] a);
    return 32'hDEAD_0000 ^ a;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one clock. The memory model samples the bus before the edge and
  // drives its response 1 time unit after the edge.
  task automatic step();
    logic        req_s;
    logic [31:0] addr_s;
    logic        rv_s;
    req_s  = imem_req;
    addr_s = imem_addr;
    rv_s   = imem_rvalid;
    if (req_s) chk("one_outstanding", {31'd0, pend && !rv_s}, 32'd0);
    @(posedge clk);
    #1;
    if (rv_s) pend = 1'b0;
    else if (pend && wl > 0) wl--;
    if (req_s) begin
      pend  = 1'b1;
      paddr = addr_s;
      wl    = lat - 1;
    end
    imem_rvalid = pend && (wl == 0);
    imem_rdata  = imem_rvalid ? mem_data(paddr) : GARBAGE;
  endtask

  task automatic exp_req(input string tag, input logic req, input logic [31:0] addr);
    chk({tag, "_req"}, {31'd0, imem_req}, {31'd0, req});
    if (req) chk({tag, "_addr"}, imem_addr, addr);
  endtask

  task automatic exp_bub(input string tag);
    chk({tag, "_valid"}, {31'd0, valid_d}, 32'd0);
    chk({tag, "_instr"}, instr_d, NOP);
  endtask

  task automatic exp_ins(input string tag, input logic [31:0] a);
    logic [31:0] a4;
    a4 = a + 32'd4;
    chk({tag, "_valid"}, {31'd0, valid_d}, 32'd1);
    chk({tag, "_instr"}, instr_d, mem_data(a));
    chk({tag, "_pc"}, pc_d, a);
    chk({tag, "_pc4"}, pc_plus4_d, a4);
  endtask

  task automatic do_reset(input int unsigned l);
    stall_f = 1'b0; stall_d = 1'b0; flush_d = 1'b0;
    pc_src_e = 1'b0; pc_target_e = '0;
    pend = 1'b0; wl = 0; paddr = '0; lat = l;
    imem_rvalid = 1'b0; imem_rdata = GARBAGE;
    rst_n = 1'b1;
    #1;
    rst_n = 1'b0;
    #1;
    chk("rst_req", {31'd0, imem_req}, 32'd0);
    chk("rst_valid", {31'd0, valid_d}, 32'd0);
    chk("rst_instr", instr_d, NOP);
    chk("rst_pc_d", pc_d, 32'd0);
    chk("rst_pc4_d", pc_plus4_d, 32'd0);
`ifdef FETCH_PERF_CNT_EN
    chk("rst_wait_cnt", fetch_wait_cnt, 32'd0);
    chk("rst_kill_cnt", fetch_kill_cnt, 32'd0);
`endif
    step();
    step();
    rst_n = 1'b1;
    #1;
  endtask

  initial begin
    // ---- 1: zero-wait memory streams one instruction per cycle
    do_reset(1);
    exp_req("s1_c0", 1'b1, 32'd0); exp_bub("s1_c0");
    step(); #1;
    exp_req("s1_c1", 1'b1, 32'd4); exp_bub("s1_c1");
    for (int k = 0; k < 4; k++) begin
      step(); #1;
      exp_req("s1_stream", 1'b1, 32'd8 + 32'd4 * k);
      exp_ins("s1_stream", 32'd4 * k);
    end

    // ---- 2: three-cycle latency
    step(); #1;
    do_reset(3);
    exp_req("s2_c0", 1'b1, 32'd0);
    step(); #1; exp_req("s2_c1", 1'b0, 32'd0);
    step(); #1; exp_req("s2_c2", 1'b0, 32'd0);
    step(); #1; exp_req("s2_c3", 1'b1, 32'd4); exp_bub("s2_c3");
    step(); #1; exp_req("s2_c4", 1'b0, 32'd0); exp_ins("s2_c4", 32'd0);
    step(); #1; exp_req("s2_c5", 1'b0, 32'd0); exp_bub("s2_c5");
    step(); #1; exp_req("s2_c6", 1'b1, 32'd8); exp_bub("s2_c6");
    step(); #1; exp_ins("s2_c7", 32'd4);
`ifdef FETCH_PERF_CNT_EN
    chk("s2_wait_cnt", fetch_wait_cnt, 32'd4);
`endif

    // ---- 3: response arrives during a two-cycle stall
    step(); #1;
    do_reset(1);
    step(); #1;
    step();
    stall_f = 1'b1; stall_d = 1'b1;
    #1;
    exp_req("s3_c2", 1'b0, 32'd0); exp_ins("s3_c2", 32'd0);
    step(); #1;
    exp_req("s3_c3", 1'b0, 32'd0); exp_ins("s3_c3", 32'd0);
    step();
    stall_f = 1'b0; stall_d = 1'b0;
    #1;
    exp_req("s3_c4", 1'b1, 32'd8); exp_ins("s3_c4", 32'd0);
    step(); #1;
    exp_req("s3_c5", 1'b1, 32'd12); exp_ins("s3_c5", 32'd4);

    // ---- 4: redirect while the request is still in flight
    step(); #1;
    do_reset(3);
    step();
    pc_src_e = 1'b1; pc_target_e = 32'h0000_0100;
    #1;
    exp_req("s4_c1", 1'b0, 32'd0);
    step();
    pc_src_e = 1'b0;
    #1;
    exp_req("s4_c2", 1'b0, 32'd0); exp_bub("s4_c2");
    step(); #1;
    exp_req("s4_c3", 1'b1, 32'h100); exp_bub("s4_c3");
    step(); #1; exp_req("s4_c4", 1'b0, 32'd0); exp_bub("s4_c4");
    step(); #1; exp_req("s4_c5", 1'b0, 32'd0);
    step(); #1; exp_req("s4_c6", 1'b1, 32'h104); exp_bub("s4_c6");
    step(); #1; exp_ins("s4_c7", 32'h100);

    // ---- 5: redirect beats stall and flush; misaligned target; PC wrap
    step(); #1;
    do_reset(1);
    step(); #1;
    step();
    pc_src_e = 1'b1; pc_target_e = 32'h0000_0203;
    stall_f = 1'b1; stall_d = 1'b1; flush_d = 1'b1;
    #1;
    exp_req("s5_c2", 1'b1, 32'h200); exp_ins("s5_c2", 32'd0);
    step();
    pc_src_e = 1'b0; stall_f = 1'b0; stall_d = 1'b0; flush_d = 1'b0;
    #1;
    exp_bub("s5_c3");
    chk("s5_c3_pc_keep", pc_d, 32'd0);
    chk("s5_c3_pc4_keep", pc_plus4_d, 32'd4);
    exp_req("s5_c3", 1'b1, 32'h204);
    step();
    pc_src_e = 1'b1; pc_target_e = 32'hFFFF_FFFC;
    #1;
    exp_ins("s5_c4", 32'h200); exp_req("s5_c4", 1'b1, 32'hFFFF_FFFC);
    step();
    pc_src_e = 1'b0;
    #1;
    exp_bub("s5_c5"); exp_req("s5_c5_wrap", 1'b1, 32'd0);
    step(); #1;
    exp_ins("s5_c6", 32'hFFFF_FFFC); exp_req("s5_c6", 1'b1, 32'd4);
`ifdef FETCH_PERF_CNT_EN
    chk("s5_kill_cnt", fetch_kill_cnt, 32'd2);
    chk("s5_wait_cnt", fetch_wait_cnt, 32'd0);
`endif

    // ---- 6: reset mid-request, stale response after release
    step(); #1;
    do_reset(3);
    step(); #1;
    exp_req("s6_c1", 1'b0, 32'd0);
    rst_n = 1'b0;
    #1;
    exp_req("s6_inrst", 1'b0, 32'd0); exp_bub("s6_inrst");
    step();
    step();
    chk("s6_stale_present", {31'd0, imem_rvalid}, 32'd1);
    imem_rdata = 32'h5A5A_5A5A;
    rst_n = 1'b1;
    #1;
    exp_req("s6_r0", 1'b1, 32'd0); exp_bub("s6_r0");
`ifdef FETCH_PERF_CNT_EN
    chk("s6_wait_cnt", fetch_wait_cnt, 32'd0);
    chk("s6_kill_cnt", fetch_kill_cnt, 32'd0);
`endif
    step(); #1; exp_req("s6_r1", 1'b0, 32'd0); exp_bub("s6_r1");
    step(); #1; exp_req("s6_r2", 1'b0, 32'd0);
    step(); #1; exp_req("s6_r3", 1'b1, 32'd4); exp_bub("s6_r3");
    step(); #1; exp_ins("s6_r4", 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage plus IF/ID pipeline register. Sits directly upstream of decode and the hazard unit.
- Owns the PC register and issues one outstanding request at a time to a variable-latency instruction memory.
- Applies stall_f, stall_d and flush_d from the hazard unit, and the pc_src_e redirect from execute.
- Inserts decode bubbles (NOP) itself whenever memory has not yet returned an instruction.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset; first fetch address.
NOP_INSTR, 32'h0000_0013, encoding written to instr_d on bubble or flush (addi x0,x0,0).

Ports:
clk  in  1  clock, rising edge.
rst_n  in  1  reset, asynchronous, active-low.
stall_f  in  1  hold PC / do not consume a fetched instruction; hazard unit always drives it equal to stall_d.
stall_d  in  1  hold IF/ID register.
flush_d  in  1  clear IF/ID register to bubble.
pc_src_e  in  1  taken branch/jump resolved in execute.
pc_target_e  in  32  redirect address.
imem_req  out  1  request valid this cycle; always accepted, no grant.
imem_addr  out  32  request address, word aligned.
imem_rvalid  in  1  response valid; at most one per request, latency >= 1 cycle.
imem_rdata  in  32  response instruction.
instr_d  out  32  instruction to decode.
pc_d  out  32  PC of instr_d.
pc_plus4_d  out  32  pc_d + 4.
valid_d  out  1  instr_d is a real instruction (0 = bubble).

Behaviour:
- Reset (async, rst_n=0) drives every output and internal register to its reset value:
  - pc_f=RESET_PC; state=IDLE; kill=0.
  - instr_d=NOP_INSTR; pc_d=0; pc_plus4_d=0; valid_d=0.
  - imem_req=0 while in reset.
  - Reset asserted mid-request: the outstanding request is abandoned. Any imem_rvalid arriving before the first new request is ignored, because state IDLE ignores rvalid.
- States:
  - IDLE: after reset. Drives imem_req=1, imem_addr=pc_f. Next state WAIT.
  - WAIT: one request outstanding.
  - HOLD: response buffered in hold_instr because stall_f was high when it arrived.
- avail = (WAIT & imem_rvalid & ~kill) | HOLD. fetched = HOLD ? hold_instr : imem_rdata.
- Consume = avail & ~stall_f & ~pc_src_e. On consume:
  - pc_f <= pc_f+4.
  - Same cycle: imem_req=1, imem_addr=pc_f+4. Next state WAIT.
  - Result: zero-wait memory sustains 1 instr/cycle.
- WAIT & imem_rvalid & ~kill & stall_f & ~pc_src_e: hold_instr <= imem_rdata; next state HOLD; no request.
- Redirect (pc_src_e=1) has priority over stall_f and over consume. pc_f <= pc_target_e.
  - WAIT with imem_rvalid (killed or not), or HOLD, or IDLE: response/buffer discarded. Same cycle imem_req=1, imem_addr=pc_target_e; next WAIT; kill<=0.
  - WAIT without imem_rvalid: kill<=1, no request. When the killed response arrives: discard it, kill<=0, same cycle imem_req=1 with imem_addr=pc_f (the target).
  - Repeated redirects while kill=1: pc_f updates, kill stays 1.
- No request is issued in any other case. Never more than one request outstanding.
- IF/ID register, priority flush_d > stall_d > load:
  - flush_d: valid_d<=0, instr_d<=NOP_INSTR; pc_d and pc_plus4_d unchanged.
  - stall_d: all hold.
  - Otherwise, if avail & ~pc_src_e: instr_d<=fetched, pc_d<=pc_f, pc_plus4_d<=pc_f+4, valid_d<=1.
  - Otherwise: bubble (valid_d<=0, instr_d<=NOP_INSTR).
- Latency: an instruction returned in cycle t appears on instr_d in cycle t+1 when unstalled.
- PC arithmetic is 32-bit modulo; 32'hFFFF_FFFC+4 wraps to 0. pc_target_e[1:0] is forced to 0 on use.

Optional Feature:
- Macro FETCH_PERF_CNT_EN.
- Defined:
  - Adds outputs fetch_wait_cnt[31:0] and fetch_kill_cnt[31:0], reset to 0 and saturating at 32'hFFFF_FFFF.
  - fetch_wait_cnt increments each cycle state≠IDLE and avail=0.
  - fetch_kill_cnt increments each time a response or HOLD buffer is discarded by a redirect.
- Undefined: ports and counters are absent; all other behaviour is identical.

Test Plan:
- Reset release, 0-wait memory returning addr-based data: imem_addr 0,4,8,... on consecutive cycles; instr_d/pc_d stream 0,4,8 with valid_d=1 from cycle 2.
- 3-cycle memory latency: imem_req pulses every 3 cycles; valid_d=1 one cycle in 3; two bubbles carry instr_d=32'h0000_0013 between.
- Response arrives with stall_f=stall_d=1 for 2 cycles: state HOLD, no new request, instr_d held. On release, buffered instr is loaded and the request for pc+4 is issued the same cycle.
- pc_src_e=1, pc_target_e=32'h100, while WAIT with no rvalid: that response is dropped, the next request is addr 32'h100, and the 32'h100 instr reaches instr_d with pc_d=32'h100.
- pc_src_e=1 together with stall_f=1 and flush_d=1: redirect taken, valid_d=0, request to target issued same cycle.
- rst_n low mid-WAIT, stale rvalid after release: ignored; first request at RESET_PC; with FETCH_PERF_CNT_EN, counters read 0 after reset.
